// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants, the fetch FSM state type and an address alignment helper.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register with a one-entry pending buffer that catches a response
// arriving while decode is stalled; flush wins over stall.
module if_id_register
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_instr,
  input  logic [31:0] rsp_pc,
  output logic        pend_vld,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  logic [31:0] pend_instr;
  logic [31:0] pend_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld       <= 1'b0;
      pend_instr     <= NOP_INSTR;
      pend_pc        <= 32'h0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      pend_vld    <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (pend_vld) begin
        pend_vld       <= 1'b0;
        if_id_instr    <= pend_instr;
        if_id_pc       <= pend_pc;
        if_id_pc_plus4 <= pend_pc + 32'd4;
        if_id_valid    <= 1'b1;
      end else if (rsp_vld) begin
        if_id_instr    <= rsp_instr;
        if_id_pc       <= rsp_pc;
        if_id_pc_plus4 <= rsp_pc + 32'd4;
        if_id_valid    <= 1'b1;
      end else begin
        // decode consumed the previous word; present a bubble until the next arrives
        if_id_valid <= 1'b0;
      end
    end else if (rsp_vld) begin
      pend_vld   <= 1'b1;
      pend_instr <= rsp_instr;
      pend_pc    <= rsp_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding fetch FSM and memory interface.
// Optional macro IF_PERF_COUNTER_EN adds the fetch_count performance counter.
module instruction_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef IF_PERF_COUNTER_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pend_vld;
  logic         rsp_accept;

  // gated by rst_n so no request is visible while reset is held
  assign imem_req   = rst_n && (state == FETCH) && !pend_vld && !stall && !branch_taken;
  assign imem_addr  = pc;
  assign rsp_accept = (state == WAIT) && imem_rvalid && !branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= word_align(RESET_PC);
      state <= FETCH;
    end else if (branch_taken) begin
      pc <= word_align(branch_target);
      // an in-flight request whose response has not arrived must still be absorbed
      if ((state != FETCH) && !imem_rvalid)
        state <= DROP;
      else
        state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req)
            state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (branch_taken),
    .stall          (stall),
    .rsp_vld        (rsp_accept),
    .rsp_instr      (imem_rdata),
    .rsp_pc         (pc),
    .pend_vld       (pend_vld),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

`ifdef IF_PERF_COUNTER_EN
  logic if_load;

  assign if_load = !branch_taken && !stall && (pend_vld || rsp_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= 32'h0;
    else if (if_load)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
